// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial LSB-first unsigned subtractor with start/busy/done handshake
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int cw = $clog2(WIDTH + 1);
  localparam logic [cw-1:0] last_cnt = cw'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] ra, rb, sh;
  logic [WIDTH-2:0] pd;
  logic [cw-1:0] cnt;
  logic br, br_nx, d, last;
  always_comb begin
    d        = ra[0] ^ rb[0] ^ br;
    br_nx    = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    sh       = {d, pd};
    last     = cnt == last_cnt;
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
    busy     = state == RUN;
    done     = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra     <= '0;
      rb     <= '0;
      pd     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (state == IDLE && start) begin
      ra  <= a;
      rb  <= b;
      pd  <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      pd  <= sh[WIDTH-1:1];
      br  <= br_nx;
      cnt <= cnt + cw'(1);
      if (last) begin
        diff   <= sh;
        borrow <= br_nx;
      end
    end
  end
endmodule
